// File: rtl/s32x_vdp_bus_master_pkg.sv
// s32x_vdp_bus_master_pkg: shared types and constants for the 32X VDP host-port bus master.
package s32x_vdp_bus_master_pkg;

  typedef enum logic [1:0] {
    VDPM_SPACE_REG  = 2'd0,
    VDPM_SPACE_PAL  = 2'd1,
    VDPM_SPACE_DRAM = 2'd2,
    VDPM_SPACE_ILL  = 2'd3
  } VDPM_SPACE_t;

  typedef enum logic [2:0] {
    VDPM_IDLE,
    VDPM_SETUP,
    VDPM_STROBE,
    VDPM_RELEASE,
    VDPM_END
  } VDPM_STATE_t;

  localparam int unsigned VDPM_TIMEOUT_DEF = 1023;

  // Requests that must never reach the VDP: the illegal space, writes with no
  // byte lanes, and palette writes that are not full words.
  function automatic logic vdpm_reject(input VDPM_SPACE_t sp, input logic we,
                                       input logic [1:0] be);
    return (sp == VDPM_SPACE_ILL) ||
           (we && (be == 2'b00)) ||
           (we && (sp == VDPM_SPACE_PAL) && (be != 2'b11));
  endfunction

endpackage

// File: rtl/s32x_vdp_bus_master.sv
// s32x_vdp_bus_master: turns one CPU-side request into a full VDP host-port
// strobe/acknowledge cycle and captures read data.
// Optional feature: define S32X_VDPM_TIMEOUT_EN to bound each wait on ACK_N
// to TIMEOUT_CYCLES clocks; otherwise the master waits indefinitely.
module s32x_vdp_bus_master
  import s32x_vdp_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = VDPM_TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [1:0]  SPACE,
  input  logic        WE,
  input  logic [1:0]  BE,
  input  logic [16:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [16:0] A,
  output logic [15:0] DO,
  input  logic [15:0] DI,
  output logic        RD_N,
  output logic        LWR_N,
  output logic        UWR_N,
  output logic        REG_CS_N,
  output logic        PAL_CS_N,
  output logic        DRAM_CS_N,
  input  logic        ACK_N
);

  VDPM_STATE_t state_q, state_d;
  VDPM_SPACE_t space_in;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic        err_flag_q, err_flag_d;
  logic [16:0] a_d;
  logic [15:0] do_d, rdata_d;
  logic        rd_n_d, lwr_n_d, uwr_n_d;
  logic        reg_cs_n_d, pal_cs_n_d, dram_cs_n_d;
  logic        busy_d, done_d, err_d;
  logic        tmo;

  assign space_in = VDPM_SPACE_t'(SPACE);

`ifdef S32X_VDPM_TIMEOUT_EN
  logic [9:0] tmo_cnt_q;

  // Wait-cycle counter, restarted on every state change so STROBE and RELEASE each get a full budget.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      tmo_cnt_q <= '0;
    else if (state_d != state_q)
      tmo_cnt_q <= '0;
    else if (state_q == VDPM_STROBE || state_q == VDPM_RELEASE)
      tmo_cnt_q <= tmo_cnt_q + 10'd1;
  end

  assign tmo = (state_q == VDPM_STROBE || state_q == VDPM_RELEASE) &&
               (tmo_cnt_q == 10'(TIMEOUT_CYCLES - 1));
`else
  // Unbounded waits: the timeout never fires; the parameter only matters when the counter is built.
  assign tmo = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // State register and all bus-facing outputs; reset parks the bus with every strobe and select high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= VDPM_IDLE;
      we_q       <= 1'b0;
      be_q       <= '0;
      err_flag_q <= 1'b0;
      A          <= '0;
      DO         <= '0;
      RDATA      <= '0;
      RD_N       <= 1'b1;
      LWR_N      <= 1'b1;
      UWR_N      <= 1'b1;
      REG_CS_N   <= 1'b1;
      PAL_CS_N   <= 1'b1;
      DRAM_CS_N  <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      be_q       <= be_d;
      err_flag_q <= err_flag_d;
      A          <= a_d;
      DO         <= do_d;
      RDATA      <= rdata_d;
      RD_N       <= rd_n_d;
      LWR_N      <= lwr_n_d;
      UWR_N      <= uwr_n_d;
      REG_CS_N   <= reg_cs_n_d;
      PAL_CS_N   <= pal_cs_n_d;
      DRAM_CS_N  <= dram_cs_n_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      ERR        <= err_d;
    end
  end

  // Next-state and next-output decode for the IDLE/SETUP/STROBE/RELEASE/END sequence.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    err_flag_d  = err_flag_q;
    a_d         = A;
    do_d        = DO;
    rdata_d     = RDATA;
    rd_n_d      = RD_N;
    lwr_n_d     = LWR_N;
    uwr_n_d     = UWR_N;
    reg_cs_n_d  = REG_CS_N;
    pal_cs_n_d  = PAL_CS_N;
    dram_cs_n_d = DRAM_CS_N;
    busy_d      = BUSY;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      VDPM_IDLE: begin
        if (REQ) begin
          we_d       = WE;
          be_d       = BE;
          busy_d     = 1'b1;
          err_flag_d = 1'b0;
          if (vdpm_reject(space_in, WE, BE)) begin
            state_d = VDPM_END;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            a_d         = ADDR;
            do_d        = WDATA;
            reg_cs_n_d  = (space_in != VDPM_SPACE_REG);
            pal_cs_n_d  = (space_in != VDPM_SPACE_PAL);
            dram_cs_n_d = (space_in != VDPM_SPACE_DRAM);
            state_d     = VDPM_SETUP;
          end
        end
      end
      VDPM_SETUP: begin
        rd_n_d  = we_q;
        uwr_n_d = ~(we_q & be_q[1]);
        lwr_n_d = ~(we_q & be_q[0]);
        state_d = VDPM_STROBE;
      end
      VDPM_STROBE: begin
        if (!ACK_N) begin
          rd_n_d  = 1'b1;
          lwr_n_d = 1'b1;
          uwr_n_d = 1'b1;
          if (!we_q)
            rdata_d = DI;
          state_d = VDPM_RELEASE;
        end else if (tmo) begin
          rd_n_d     = 1'b1;
          lwr_n_d    = 1'b1;
          uwr_n_d    = 1'b1;
          err_flag_d = 1'b1;
          state_d    = VDPM_RELEASE;
        end
      end
      VDPM_RELEASE: begin
        // A late ACK rise on the timeout cycle still counts as a clean finish.
        if (ACK_N || tmo) begin
          reg_cs_n_d  = 1'b1;
          pal_cs_n_d  = 1'b1;
          dram_cs_n_d = 1'b1;
          done_d      = 1'b1;
          err_d       = err_flag_q | ~ACK_N;
          state_d     = VDPM_END;
        end
      end
      VDPM_END: begin
        busy_d  = 1'b0;
        state_d = VDPM_IDLE;
      end
      default: state_d = VDPM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_s32x_vdp_bus_master.sv
// tb_s32x_vdp_bus_master: directed bench for the VDP bus master with a
// queue-based scoreboard and a cycle-level VDP responder model.
module tb_s32x_vdp_bus_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic [1:0]  SPACE = '0;
  logic        WE = 1'b0;
  logic [1:0]  BE = '0;
  logic [16:0] ADDR = '0;
  logic [15:0] WDATA = '0;
  logic [15:0] DI = '0;
  logic        ACK_N = 1'b1;
  logic [15:0] RDATA, DO;
  logic [16:0] A;
  logic        BUSY, DONE, ERR;
  logic        RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N;

  always #5 CLK = ~CLK;

  s32x_vdp_bus_master #(.TIMEOUT_CYCLES(1023)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .SPACE(SPACE), .WE(WE), .BE(BE),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .A(A), .DO(DO), .DI(DI), .RD_N(RD_N), .LWR_N(LWR_N),
    .UWR_N(UWR_N), .REG_CS_N(REG_CS_N), .PAL_CS_N(PAL_CS_N),
    .DRAM_CS_N(DRAM_CS_N), .ACK_N(ACK_N)
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          stb;
    logic [2:0]  seen;   // {rd, uwr, lwr} ever low
    logic [2:0]  cs;     // {reg, pal, dram} ever low
    logic [16:0] a;
    logic [15:0] d;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall = 0;
  int          wait_cnt = 0;
  logic [15:0] di_val = '0;
  logic [15:0] rdata_m = '0;

  int          m_stb = 0;
  logic [2:0]  m_seen = '0, m_cs = '0;
  logic [16:0] m_a = '0;
  logic [15:0] m_d = '0;
  logic        m_av = 1'b0, m_unst = 1'b0, prev_done = 1'b0;
  exp_t        m_e;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic err, input int lat, input int stb, input logic [2:0] seen,
                              input logic [2:0] cs, input logic [16:0] a, input logic [15:0] d);
    exp_t e;
    e.err = err; e.rdata = rdata_m; e.lat = lat; e.stb = stb;
    e.seen = seen; e.cs = cs; e.a = a; e.d = d; e.stamp = 0;
    return e;
  endfunction

  // VDP responder: pulses ACK_N low for one cycle after the strobes have been low for 'stall'+1 cycles.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if ((!RD_N || !UWR_N || !LWR_N) && ACK_N) begin
      if (wait_cnt >= stall) begin
        ACK_N    <= 1'b0;
        DI       <= di_val;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      ACK_N    <= 1'b1;
      wait_cnt <= 0;
    end
  end

  // Monitor: accumulates bus activity per transaction and checks it against the scoreboard on DONE.
  always @(negedge CLK) begin
    if (RST) begin
      m_stb = 0; m_seen = '0; m_cs = '0; m_a = '0; m_d = '0;
      m_av = 1'b0; m_unst = 1'b0; prev_done = 1'b0;
    end else begin
      if (!RD_N || !UWR_N || !LWR_N) m_stb++;
      m_seen |= {~RD_N, ~UWR_N, ~LWR_N};
      m_cs   |= {~REG_CS_N, ~PAL_CS_N, ~DRAM_CS_N};
      if (!(REG_CS_N && PAL_CS_N && DRAM_CS_N)) begin
        if (m_av && (A != m_a || DO != m_d)) m_unst = 1'b1;
        m_a = A; m_d = DO; m_av = 1'b1;
      end
      if (DONE) begin
        chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got DONE at cycle %0d, expected none", cyc);
        end else begin
          m_e = sb.pop_front();
          chk("err",        {31'd0, ERR},    {31'd0, m_e.err});
          chk("latency",    cyc - m_e.stamp, m_e.lat);
          chk("strobe_cyc", m_stb,           m_e.stb);
          chk("strobes",    {29'd0, m_seen}, {29'd0, m_e.seen});
          chk("chip_sel",   {29'd0, m_cs},   {29'd0, m_e.cs});
          chk("addr",       {15'd0, m_a},    {15'd0, m_e.a});
          chk("wdata",      {16'd0, m_d},    {16'd0, m_e.d});
          chk("rdata",      {16'd0, RDATA},  {16'd0, m_e.rdata});
          chk("a_do_stable",{31'd0, m_unst}, 32'd0);
        end
        m_stb = 0; m_seen = '0; m_cs = '0; m_a = '0; m_d = '0;
        m_av = 1'b0; m_unst = 1'b0;
      end
      prev_done = DONE;
    end
  end

  task automatic issue(input logic [1:0] sp, input logic we, input logic [1:0] be,
                       input logic [16:0] ad, input logic [15:0] wd, input logic [15:0] di,
                       input int st, input logic track, input exp_t e);
    @(negedge CLK);
    stall = st; di_val = di;
    SPACE = sp; WE = we; BE = be; ADDR = ad; WDATA = wd; REQ = 1'b1;
    if (track) begin
      e.stamp = cyc;
      sb.push_back(e);
    end
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int i = 0;
    while (sb.size() != 0 && i < limit) begin
      @(negedge CLK);
      i++;
    end
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_idle_bus(input string nm);
    chk({nm, "_strobes"}, {29'd0, RD_N, LWR_N, UWR_N}, 32'h7);
    chk({nm, "_cs"}, {29'd0, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h7);
    chk({nm, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy_mid;
    exp_t e;

    repeat (3) @(negedge CLK);
    check_idle_bus("reset");
    chk("reset_a",     {15'd0, A},     32'd0);
    chk("reset_do",    {16'd0, DO},    32'd0);
    chk("reset_rdata", {16'd0, RDATA}, 32'd0);
    chk("reset_done_err", {30'd0, DONE, ERR}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Register write, full word, immediate ACK.
    issue(2'd0, 1'b1, 2'b11, 17'h00005, 16'h1234, 16'h0, 0, 1'b1,
          mk(1'b0, 5, 2, 3'b011, 3'b100, 17'h00005, 16'h1234));
    wait_done(20, "reg_write_complete");

    // DRAM read, back-to-back.
    rdata_m = 16'hBEEF;
    issue(2'd2, 1'b0, 2'b00, 17'h1ABCD, 16'h0000, 16'hBEEF, 0, 1'b1,
          mk(1'b0, 5, 2, 3'b100, 3'b001, 17'h1ABCD, 16'h0000));
    wait_done(20, "dram_read_complete");

    // DRAM low-byte write.
    issue(2'd2, 1'b1, 2'b01, 17'h00100, 16'h00A5, 16'h0, 0, 1'b1,
          mk(1'b0, 5, 2, 3'b001, 3'b001, 17'h00100, 16'h00A5));
    wait_done(20, "byte_write_complete");

    // Palette write with upper byte only: rejected, no bus cycle.
    issue(2'd1, 1'b1, 2'b10, 17'h00003, 16'hFFFF, 16'h0, 0, 1'b1,
          mk(1'b1, 1, 0, 3'b000, 3'b000, 17'h0, 16'h0));
    wait_done(20, "pal_reject_complete");

    // Palette word write with a 3-cycle ACK delay; a second REQ while busy must be ignored.
    issue(2'd1, 1'b1, 2'b11, 17'h0001F, 16'h7C00, 16'h0, 3, 1'b1,
          mk(1'b0, 8, 5, 3'b011, 3'b010, 17'h0001F, 16'h7C00));
    @(negedge CLK);
    SPACE = 2'd3; WE = 1'b0; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    wait_done(30, "pal_write_complete");

    // Palette read, 1-cycle ACK delay.
    rdata_m = 16'h0F0F;
    issue(2'd1, 1'b0, 2'b00, 17'h00010, 16'h0000, 16'h0F0F, 1, 1'b1,
          mk(1'b0, 6, 3, 3'b100, 3'b010, 17'h00010, 16'h0000));
    wait_done(20, "pal_read_complete");

    // Illegal space and empty-lane write: both rejected, RDATA held.
    issue(2'd3, 1'b0, 2'b11, 17'h00001, 16'h0000, 16'hDEAD, 0, 1'b1,
          mk(1'b1, 1, 0, 3'b000, 3'b000, 17'h0, 16'h0));
    wait_done(20, "ill_space_complete");
    issue(2'd0, 1'b1, 2'b00, 17'h00002, 16'h5A5A, 16'h0, 0, 1'b1,
          mk(1'b1, 1, 0, 3'b000, 3'b000, 17'h0, 16'h0));
    wait_done(20, "be00_reject_complete");

    // ACK withheld for 2000 cycles on a DRAM read.
`ifdef S32X_VDPM_TIMEOUT_EN
    e = mk(1'b1, 1026, 1023, 3'b100, 3'b001, 17'h0ABCD, 16'h0000);
    busy_mid = 1'b0;
`else
    rdata_m = 16'h5555;
    e = mk(1'b0, 2005, 2002, 3'b100, 3'b001, 17'h0ABCD, 16'h0000);
    busy_mid = 1'b1;
`endif
    issue(2'd2, 1'b0, 2'b00, 17'h0ABCD, 16'h0000, 16'h5555, 2000, 1'b1, e);
    repeat (1500) @(negedge CLK);
    chk("busy_while_stalled", {31'd0, BUSY}, {31'd0, busy_mid});
    wait_done(1000, "stall_complete");

    // Reset pulsed while the strobes are low.
    issue(2'd0, 1'b1, 2'b11, 17'h00007, 16'h9999, 16'h0, 50, 1'b0,
          mk(1'b0, 0, 0, 3'b000, 3'b000, 17'h0, 16'h0));
    repeat (2) @(negedge CLK);
    chk("pre_reset_in_strobe", {31'd0, UWR_N}, 32'd0);
    #1 RST = 1'b1;
    #1;
    check_idle_bus("async_reset");
    chk("async_reset_rdata", {16'd0, RDATA}, 32'd0);
    rdata_m = 16'h0000;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Normal read after reset.
    rdata_m = 16'hCAFE;
    issue(2'd2, 1'b0, 2'b00, 17'h10000, 16'h0000, 16'hCAFE, 0, 1'b1,
          mk(1'b0, 5, 2, 3'b100, 3'b001, 17'h10000, 16'h0000));
    wait_done(20, "post_reset_read_complete");

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
